// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and round-robin helpers for uart_tx_arbiter
package uart_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

    localparam int MAX_REQ = 16;

    function automatic int idw_of(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // First set bit of valid at or after ptr, wrapping at nreq; returns ptr when none is set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int nreq);
        int idx;
        int j;
        idx = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                j = ptr + k;
                if (j >= nreq) j = j - nreq;
                if (valid[j]) idx = j;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotate-priority encoder starting at ptr
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_vld_o
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req_i;
        gnt_idx_o          = IDW'(rr_pick(req_ext, int'(ptr_i), NREQ));
    end

    assign gnt_vld_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter in front of the UART TX FIFO; optional idle timeout via UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [NREQ-1:0]             req_valid_i,
    input  logic [NREQ*DBIT-1:0]        req_data_i,
    input  logic [NREQ-1:0]             req_last_i,
    output logic [NREQ-1:0]             req_ready_o,
    output logic [DBIT-1:0]             w_data_o,
    output logic                        wr_uart_o,
    input  logic                        tx_full_i,
    output logic                        busy_o,
    output logic [idw_of(NREQ)-1:0]     grant_id_o,
    output logic                        timeout_evt_o
);

    localparam int IDW = idw_of(NREQ);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] pick_idx;
    logic           pick_vld;
    logic           timeout_evt_q, timeout_evt_d;
    logic           g_valid, g_last, accept, timeout_hit;

    rr_priority_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_i     (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (pick_idx),
        .gnt_vld_o (pick_vld)
    );

    assign g_valid       = req_valid_i[grant_q];
    assign g_last        = req_last_i[grant_q];
    assign w_data_o      = req_data_i[int'(grant_q)*DBIT +: DBIT];
    // Explicit wrap so non-power-of-two NREQ never points past the last requester.
    assign ptr_next      = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
    assign busy_o        = (state_q == GRANT);
    assign grant_id_o    = grant_q;
    assign timeout_evt_o = timeout_evt_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt_q, idle_cnt_d;

    assign timeout_hit = (state_q == GRANT) && (idle_cnt_q == CW'(TIMEOUT));

    // Held at zero in IDLE so every grant starts counting from zero.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q == IDLE || g_valid) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        timeout_evt_d = 1'b0;
        req_ready_o   = '0;
        wr_uart_o     = 1'b0;
        accept        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (timeout_hit) begin
                    state_d       = IDLE;
                    rr_ptr_d      = ptr_next;
                    timeout_evt_d = 1'b1;
                end else begin
                    req_ready_o[grant_q] = ~tx_full_i;
                    accept               = g_valid & ~tx_full_i;
                    wr_uart_o            = accept;
                    if (accept && g_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = ptr_next;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (timeout case under UART_TX_ARB_TIMEOUT_EN)
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int TOUT = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [3:0]  rv, rl, rdy;
    logic [31:0] rd;
    logic [7:0]  wd;
    logic        wr, full, busy, tevt;
    logic [1:0]  gid;

    logic [2:0]  rv3, rl3, rdy3;
    logic [23:0] rd3;
    logic [7:0]  wd3;
    logic        wr3, busy3, tevt3;
    logic [1:0]  gid3;

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(TOUT)) dut (
        .clk_i(clk), .reset_n_i(rstn), .req_valid_i(rv), .req_data_i(rd), .req_last_i(rl),
        .req_ready_o(rdy), .w_data_o(wd), .wr_uart_o(wr), .tx_full_i(full), .busy_o(busy),
        .grant_id_o(gid), .timeout_evt_o(tevt)
    );

    uart_tx_arbiter #(.NREQ(3), .DBIT(8), .TIMEOUT(TOUT)) dut3 (
        .clk_i(clk), .reset_n_i(rstn), .req_valid_i(rv3), .req_data_i(rd3), .req_last_i(rl3),
        .req_ready_o(rdy3), .w_data_o(wd3), .wr_uart_o(wr3), .tx_full_i(1'b0), .busy_o(busy3),
        .grant_id_o(gid3), .timeout_evt_o(tevt3)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [8:0] rq[4][$];
    int lg_cyc[$], lg_gid[$], lg_dat[$], lg_full[$];
    int gr_cyc[$], gr_id[$], ev_cyc[$];
    logic prev_busy = 1'b0;

    bit m_busy = 1'b0, m_evt = 1'b0;
    int m_gid = 0, m_ptr = 0, m_idle = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: who owns the path, where the pointer sits, how long the owner has been idle.
    always @(negedge clk) begin
        bit hit;
        bit ewr;
        int erdy;
        cyc++;
        hit  = TO_EN && m_busy && (m_idle == TOUT);
        ewr  = m_busy && !hit && !full && rv[m_gid];
        erdy = (m_busy && !hit && !full) ? (1 << m_gid) : 0;
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("grant_id", gid, m_gid);
            chk("req_ready", rdy, erdy);
            chk("wr_uart", wr, ewr);
            chk("timeout_evt", tevt, m_evt);
            if (ewr) chk("w_data", wd, rd[m_gid*8 +: 8]);
            if (wr) begin
                lg_cyc.push_back(cyc); lg_gid.push_back(gid);
                lg_dat.push_back(wd);  lg_full.push_back(full);
            end
            if (busy && !prev_busy) begin gr_cyc.push_back(cyc); gr_id.push_back(gid); end
            if (tevt) ev_cyc.push_back(cyc);
            prev_busy = busy;
        end
        if (!rstn) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_evt = 0; m_idle = 0;
        end else begin
            m_evt = 0;
            if (!m_busy) begin
                for (int k = N - 1; k >= 0; k--)
                    if (rv[(m_ptr + k) % N]) m_gid = (m_ptr + k) % N;
                if (|rv) begin m_busy = 1; m_idle = 0; end
            end else if (hit) begin
                m_busy = 0; m_ptr = (m_gid + 1) % N; m_evt = 1;
            end else begin
                if (ewr && rl[m_gid]) begin m_busy = 0; m_ptr = (m_gid + 1) % N; end
                m_idle = rv[m_gid] ? 0 : m_idle + 1;
            end
        end
    end

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                rv[i] = 1'b1; rd[i*8 +: 8] = rq[i][0][7:0]; rl[i] = rq[i][0][8];
            end else begin
                rv[i] = 1'b0; rd[i*8 +: 8] = 8'h00; rl[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        logic [3:0] acc;
        @(negedge clk);
        acc = rv & rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        refresh();
    endtask

    task automatic clear_logs();
        lg_cyc.delete(); lg_gid.delete(); lg_dat.delete(); lg_full.delete();
        gr_cyc.delete(); gr_id.delete(); ev_cyc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0; full = 1'b0;
        rv3 = '0; rl3 = '0; rd3 = '0;
        for (int i = 0; i < N; i++) rq[i].delete();
        refresh();
        cycle(); cycle();
        rstn = 1'b1;
        chk_en = 1'b1;
        clear_logs();
    endtask

    task automatic run_idle(input int maxc, input string name);
        int c;
        c = 0;
        do begin cycle(); c++; end while ((busy !== 1'b0 || pending()) && c < maxc);
        chk({name, " finished"}, {31'd0, (busy !== 1'b0) || pending()}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, c;
        int exp_b[3] = '{'h41, 'h42, 'h43};
        rv = '0; rl = '0; rd = '0; full = 1'b0; rstn = 1'b0;

        // reset state and single-requester burst
        do_reset();
        chk("rst busy", busy, 0); chk("rst grant_id", gid, 0); chk("rst wr_uart", wr, 0);
        chk("rst req_ready", rdy, 0); chk("rst timeout_evt", tevt, 0);
        rq[1].push_back({1'b0, 8'h41}); rq[1].push_back({1'b0, 8'h42}); rq[1].push_back({1'b1, 8'h43});
        refresh();
        t0 = cyc + 1;
        run_idle(20, "burst");
        chk("burst grants", gr_id.size(), 1);
        if (gr_id.size() == 1) begin
            chk("burst grant id", gr_id[0], 1); chk("burst grant cycle", gr_cyc[0], t0 + 1);
        end
        chk("burst writes", lg_dat.size(), 3);
        if (lg_dat.size() == 3)
            for (int i = 0; i < 3; i++) begin
                chk("burst data", lg_dat[i], exp_b[i]);
                chk("burst write cycle", lg_cyc[i], t0 + 1 + i);
            end

        // pointer is now 2: requester 2 beats requester 0
        clear_logs();
        rq[0].push_back({1'b1, 8'h10}); rq[2].push_back({1'b1, 8'h20});
        refresh();
        run_idle(20, "after burst");
        chk("ptr grants", gr_id.size(), 2);
        if (gr_id.size() == 2) begin chk("ptr first", gr_id[0], 2); chk("ptr second", gr_id[1], 0); end

        // round-robin fairness with 2-byte messages
        do_reset();
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < N; i++) begin
                rq[i].push_back({1'b0, 8'(i*16 + m*2)});
                rq[i].push_back({1'b1, 8'(i*16 + m*2 + 1)});
            end
        refresh();
        t0 = cyc + 1;
        run_idle(100, "round robin");
        chk("rr writes", lg_dat.size(), 24);
        if (lg_dat.size() == 24)
            for (int j = 0; j < 24; j++) begin
                chk("rr gid", lg_gid[j], (j/2) % 4);
                chk("rr data", lg_dat[j], ((j/2) % 4)*16 + ((j/2)/4)*2 + (j % 2));
                chk("rr cycle", lg_cyc[j], t0 + 1 + 3*(j/2) + (j % 2));
            end

        // back-pressure on requester 2
        do_reset();
        rq[2].push_back({1'b0, 8'hA0}); rq[2].push_back({1'b0, 8'hA1});
        rq[2].push_back({1'b0, 8'hA2}); rq[2].push_back({1'b1, 8'hA3});
        refresh();
        t0 = cyc + 1;
        c = 0;
        do begin cycle(); c++; end while (lg_dat.size() < 2 && c < 10);
        chk("bp two bytes", lg_dat.size(), 2);
        full = 1'b1;
        repeat (3) cycle();
        full = 1'b0;
        cycle();
        full = 1'b1;
        repeat (2) cycle();
        chk("bp hold busy", busy, 1); chk("bp hold ready", rdy, 0); chk("bp hold wr", wr, 0);
        full = 1'b0;
        #1;
        chk("bp ready", rdy, 4'b0100); chk("bp wr", wr, 1);
        cycle();
        chk("bp release", busy, 0);
        chk("bp writes", lg_dat.size(), 4);
        if (lg_dat.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("bp data", lg_dat[i], 'hA0 + i);
                chk("bp full at write", lg_full[i], 0);
            end
            chk("bp first cycle", lg_cyc[0], t0 + 1);
            chk("bp gap 1-2", lg_cyc[2] - lg_cyc[1], 4);
            chk("bp gap 2-3", lg_cyc[3] - lg_cyc[2], 3);
        end

        // reset in the middle of a message
        do_reset();
        for (int i = 0; i < 5; i++) rq[0].push_back({(i == 4), 8'(8'h30 + i)});
        refresh();
        c = 0;
        do begin cycle(); c++; end while (lg_dat.size() < 2 && c < 10);
        chk("mid reset two bytes", lg_dat.size(), 2);
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        chk("mid reset busy", busy, 0); chk("mid reset grant_id", gid, 0); chk("mid reset wr", wr, 0);
        rq[0].delete();
        clear_logs();
        rq[3].push_back({1'b1, 8'h55});
        refresh();
        run_idle(20, "after reset");
        chk("after reset grants", gr_id.size(), 1);
        if (gr_id.size() == 1) chk("after reset grant id", gr_id[0], 3);
        chk("after reset writes", lg_dat.size(), 1);
        if (lg_dat.size() == 1) chk("after reset data", lg_dat[0], 'h55);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // requester 1 stalls after one byte, requester 2 waits
        do_reset();
        rq[1].push_back({1'b0, 8'h61}); rq[2].push_back({1'b1, 8'h62});
        refresh();
        t0 = cyc + 1;
        run_idle(40, "timeout");
        chk("to events", ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) chk("to event cycle", ev_cyc[0], t0 + 11);
        chk("to grants", gr_id.size(), 2);
        if (gr_id.size() == 2) begin
            chk("to first", gr_id[0], 1); chk("to second", gr_id[1], 2);
            chk("to second cycle", gr_cyc[1], t0 + 12);
        end
        chk("to writes", lg_dat.size(), 2);
        if (lg_dat.size() == 2) begin chk("to data0", lg_dat[0], 'h61); chk("to data1", lg_dat[1], 'h62); end
`endif

        // NREQ=3 pointer wrap after requester 2
        do_reset();
        rv3 = 3'b100; rl3 = 3'b100; rd3 = {8'h77, 8'h00, 8'h00};
        cycle();
        chk("wrap3 grant", gid3, 2); chk("wrap3 busy", busy3, 1);
        chk("wrap3 wr", wr3, 1); chk("wrap3 data", wd3, 'h77); chk("wrap3 ready", rdy3, 3'b100);
        cycle();
        chk("wrap3 idle", busy3, 0);
        rv3 = 3'b101; rl3 = 3'b101; rd3 = {8'h20, 8'h00, 8'h10};
        cycle();
        chk("wrap3 second grant", gid3, 0); chk("wrap3 second busy", busy3, 1);
        chk("wrap3 second data", wd3, 'h10); chk("wrap3 evt", tevt3, 0);
        cycle();
        chk("wrap3 second done", busy3, 0);
        rv3 = '0; rl3 = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit path among `NREQ` independent byte-stream requesters. It arbitrates round-robin at message granularity: a grant is held from the first byte until the byte marked `last`, so messages never interleave. It sits in front of the transmit FIFO in the UART top level and drives its `w_data` / `wr_uart` inputs, honouring `tx_full` as back-pressure.

## Interface
- `NREQ`, 4: number of requesters, range 2..16.
- `DBIT`, 8: data width; matches the UART `DBIT`.
- `TIMEOUT`, 255: idle-cycle limit on a granted requester. Used only with the timeout feature; must be ≥1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `req_valid` in NREQ: requester i has a byte on offer.
- `req_data` in NREQ*DBIT: byte of requester i at `[i*DBIT +: DBIT]`.
- `req_last` in NREQ: byte of requester i is the last byte of its message.
- `req_ready` out NREQ: byte of requester i is accepted this cycle when `req_valid[i]` is also high.
- `w_data` out DBIT: byte to the TX FIFO.
- `wr_uart` out 1: TX FIFO write strobe.
- `tx_full` in 1: TX FIFO full.
- `busy` out 1: a grant is active.
- `grant_id` out clog2(NREQ): index of the current or most recent grantee.
- `timeout_evt` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- **State machine.** Two states, `IDLE` and `GRANT`.
- **IDLE.**
  - If any `req_valid` is high, select the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap-around.
  - Register the selection into `grant_id`, set `busy`, and go to `GRANT`.
  - No byte is accepted in `IDLE`.
- **GRANT, with g = `grant_id`.**
  - `req_ready[g] = ~tx_full`. All other `req_ready` bits are 0.
  - `wr_uart = req_valid[g] & ~tx_full`.
  - `w_data = req_data[g]`. Its value is don't-care when `wr_uart` is 0; implement it as a mux with no gating.
  - An accepted byte with `req_last[g]` high ends the message: go to `IDLE` and set `rr_ptr = (g+1) mod NREQ`.
- **Stalls.**
  - Deasserting `req_valid[g]` mid-message is legal; the grant is held.
  - `req_valid` from other requesters is ignored while a grant is active.
- **Non-power-of-two `NREQ`.** Pointer wrap is explicit: when `rr_ptr == NREQ-1`, the increment goes to 0.
- **Reset.** `reset_n` low on a clock edge overrides everything:
  - State goes to `IDLE`.
  - `rr_ptr`, `grant_id`, `busy`, and `timeout_evt` go to 0.
  - `wr_uart` and `req_ready` are 0 combinationally as a consequence of `IDLE`.
  - A message interrupted by reset is abandoned. The FIFO keeps any bytes already written.

## Timing
- **Arbitration latency.** 1 cycle: `req_valid` is seen in `IDLE` at edge n, `GRANT` is active in cycle n+1, and the first byte can be written in cycle n+1.
- **Transfer.** Zero-latency, combinational pass-through. One byte per cycle while `req_valid[g]` is high and `tx_full` is low.
- **Gap between messages.** Minimum 1 idle cycle (the `IDLE` arbitration cycle), even when the same requester requests again.
- **Single-byte message** (`valid` and `last` in the first `GRANT` cycle): 2 cycles from `IDLE` back to `IDLE`.
- **`tx_full` in the `last` cycle:** the byte is not accepted and the grant holds until the FIFO has space.
- **`timeout_evt`:** registered, high for exactly 1 cycle.

## Configuration
- **Macro:** `UART_TX_ARB_TIMEOUT_EN`.
- **Defined:**
  - An idle counter, width clog2(TIMEOUT+1), clears on entry to `GRANT` and on every cycle where `req_valid[g]` is high.
  - The counter increments on each `GRANT` cycle where `req_valid[g]` is low.
  - A `tx_full` stall with `req_valid[g]` high does not count.
  - On the cycle the counter equals `TIMEOUT`:
    - Go to `IDLE`, set `rr_ptr = g+1`, and pulse `timeout_evt` on the next cycle.
    - `req_ready[g]` is 0 in that cycle.
- **Undefined:**
  - No counter; the grant is held indefinitely.
  - `timeout_evt` is tied to 0.

## Structure
- **Package `uart_arb_pkg`:**
  - State enum `arb_state_t` {`IDLE`, `GRANT`}.
  - Function `rr_pick(valid, ptr)` returning the index.
  - Localparam helper for `IDW = $clog2(NREQ)`, with a minimum of 1.
- **Sub-module `rr_priority_picker`:** combinational rotate-priority encoder.
  - Inputs: `req` (NREQ bits), `ptr`.
  - Outputs: `gnt_idx`, `gnt_vld`.
- The top module holds the FSM, `rr_ptr`, the datapath mux and the optional timeout counter.

## Test plan
- **Single-requester burst.** Reset; requester 1 sends bytes 0x41, 0x42, 0x43 (last on 0x43) with `tx_full`=0. Required: `busy` rises 1 cycle after `valid`; `wr_uart` is high on 3 consecutive cycles with `w_data` = 0x41, 0x42, 0x43; then `IDLE`, with `rr_ptr` = 2.
- **Round-robin fairness.** All 4 requesters continuously send 2-byte messages. Required: grant order 0, 1, 2, 3, 0, …; each message is contiguous; exactly 1 idle cycle between messages.
- **Back-pressure.** Requester 2 sends a 4-byte message; `tx_full` is high for 3 cycles after byte 2 and held high in the `last` cycle. Required: no `wr_uart` and no `req_ready[2]` while full; all 4 bytes are written in order; the grant is released only after the last byte is accepted.
- **Reset mid-message.** Requester 0 is granted and has sent 2 of 5 bytes; `reset_n` is pulled low for 1 cycle. Required: the next cycle shows `busy`=0, `grant_id`=0, `wr_uart`=0; a new request from requester 3 is granted afterwards.
- **Timeout** (`UART_TX_ARB_TIMEOUT_EN`, `TIMEOUT`=8). Requester 1 sends 1 non-last byte, then drops `valid`; requester 2 is waiting. Required: the grant is revoked after 8 idle cycles; `timeout_evt` pulses once; requester 2 is granted next.
- **Pointer wrap, `NREQ`=3.** Requester 2 completes a message, then requesters 0 and 2 both request. Required: requester 0 is granted first.
